// File: rtl/link_pkg.sv
// link_pkg: constants and types shared by the inter-board link transmitter,
// receiver and role-select logic.
// Optional build macro LINK_PARITY_EN adds the PARITY frame state (8E1).
package link_pkg;

   localparam int LINK_CLK_FREQ_DEFAULT = 100_000_000;
   localparam int LINK_BAUD_DEFAULT     = 115_200;

   // Board role codes driven by the role-select switches.
   localparam logic [1:0] ROLE_UNSET  = 2'd0;
   localparam logic [1:0] ROLE_MASTER = 2'd1;
   localparam logic [1:0] ROLE_SLAVE  = 2'd2;
   localparam logic [1:0] ROLE_SOLO   = 2'd3;

   // Frame FSM states; encodings are shared with the transmitter so that
   // debug probes read the same on both boards.
   typedef enum logic [2:0] {
      LINK_IDLE   = 3'd0,
      LINK_START  = 3'd1,
      LINK_DATA   = 3'd2,
`ifdef LINK_PARITY_EN
      LINK_PARITY = 3'd3,
`endif
      LINK_STOP   = 3'd4
   } link_state_e;

   // Whole clocks per bit; the fractional remainder is absorbed by
   // re-centring on every start bit.
   function automatic int link_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Even-parity bit for a data byte: 1 when the byte has an odd number of ones.
   function automatic logic link_even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/link_sync2.sv
// link_sync2: two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so an idle-high line does not look like a
// start bit while coming out of reset.
module link_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic basys_clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge basys_clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/board_link_rx.sv
// board_link_rx: slave-side UART-style receiver for the inter-board link.
// Decodes 8N1 frames, or 8E1 when built with LINK_PARITY_EN, from the master
// board's Pmod line and hands each byte to the game logic with a one-cycle
// strobe. Only active while board_type selects the slave role.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for rx_s low
// START  | counting half a bit to re-check the start bit at its centre
// DATA   | sampling 8 data bits at bit centres, LSB first
// PARITY | sampling the even-parity bit (LINK_PARITY_EN builds only)
// STOP   | sampling the stop bit, issuing the result strobe
module board_link_rx
   import link_pkg::*;
#(
   parameter int CLK_FREQ = LINK_CLK_FREQ_DEFAULT,
   parameter int BAUD     = LINK_BAUD_DEFAULT
) (
   input  logic       basys_clk,
   input  logic       reset,
   input  logic [1:0] board_type,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
`ifdef LINK_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int         CLKS_PER_BIT = link_clks_per_bit(CLK_FREQ, BAUD);
   localparam logic [9:0] HALF_LAST    = 10'(CLKS_PER_BIT / 2 - 1);
   localparam logic [9:0] FULL_LAST    = 10'(CLKS_PER_BIT - 1);

   logic        rx_s;
   logic        enable;

   link_state_e state, state_nxt;
   logic [9:0]  baud_cnt, baud_cnt_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic [7:0]  shift_reg, shift_reg_nxt;
   logic [7:0]  rx_data_nxt;
   logic        rx_valid_nxt;
   logic        frame_err_nxt;
`ifdef LINK_PARITY_EN
   logic        par_bad, par_bad_nxt;
   logic        parity_err_nxt;
`endif

   link_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .basys_clk (basys_clk),
      .reset     (reset),
      .d         (rx_in),
      .q         (rx_s)
   );

   assign enable = (board_type == ROLE_SLAVE);
   assign busy   = (state != LINK_IDLE);

   // Next-state, counter and strobe decode for one frame.
   always_comb begin
      state_nxt     = state;
      baud_cnt_nxt  = baud_cnt + 10'd1;
      bit_idx_nxt   = bit_idx;
      shift_reg_nxt = shift_reg;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef LINK_PARITY_EN
      par_bad_nxt    = par_bad;
      parity_err_nxt = 1'b0;
`endif

      if (!enable) begin
         // Any role other than slave drops the frame on this very edge.
         state_nxt    = LINK_IDLE;
         baud_cnt_nxt = 10'd0;
         bit_idx_nxt  = 3'd0;
      end else begin
         case (state)
            LINK_IDLE: begin
               baud_cnt_nxt = 10'd0;
               if (!rx_s) begin
                  state_nxt = LINK_START;
               end
            end

            LINK_START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt_nxt = 10'd0;
                  bit_idx_nxt  = 3'd0;
`ifdef LINK_PARITY_EN
                  par_bad_nxt  = 1'b0;
`endif
                  // A line back high at mid start bit was only a glitch.
                  state_nxt    = rx_s ? LINK_IDLE : LINK_DATA;
               end
            end

            LINK_DATA: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt_nxt  = 10'd0;
                  shift_reg_nxt = {rx_s, shift_reg[7:1]};
                  bit_idx_nxt   = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef LINK_PARITY_EN
                     state_nxt = LINK_PARITY;
`else
                     state_nxt = LINK_STOP;
`endif
                  end
               end
            end

`ifdef LINK_PARITY_EN
            LINK_PARITY: begin
               if (baud_cnt == FULL_LAST) begin
                  baud_cnt_nxt = 10'd0;
                  par_bad_nxt  = rx_s ^ link_even_parity(shift_reg);
                  state_nxt    = LINK_STOP;
               end
            end
`endif

            LINK_STOP: begin
               if (baud_cnt == FULL_LAST) begin
                  // Back to IDLE at mid stop bit leaves half a bit of slack
                  // for a back-to-back start bit.
                  baud_cnt_nxt = 10'd0;
                  state_nxt    = LINK_IDLE;
                  if (!rx_s) begin
                     frame_err_nxt = 1'b1;
`ifdef LINK_PARITY_EN
                  end else if (par_bad) begin
                     parity_err_nxt = 1'b1;
`endif
                  end else begin
                     rx_data_nxt  = shift_reg;
                     rx_valid_nxt = 1'b1;
                  end
               end
            end

            default: begin
               state_nxt    = LINK_IDLE;
               baud_cnt_nxt = 10'd0;
            end
         endcase
      end
   end

   // State, counters, data path and registered strobes.
   always_ff @(posedge basys_clk) begin
      if (reset) begin
         state     <= LINK_IDLE;
         baud_cnt  <= 10'd0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef LINK_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift_reg <= shift_reg_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         frame_err <= frame_err_nxt;
`ifdef LINK_PARITY_EN
         par_bad    <= par_bad_nxt;
         parity_err <= parity_err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_board_link_rx.sv
// tb_board_link_rx: drives serial frames onto rx_in and checks every output
// strobe against a queue of expected events computed from the frame rules.
module tb_board_link_rx;
   import link_pkg::*;

   localparam int CPB = 100_000_000 / 115_200;
`ifdef LINK_PARITY_EN
   localparam int FRAME_LAT = 2 + 1 + CPB / 2 + 9 * CPB + CPB;
`else
   localparam int FRAME_LAT = 2 + 1 + CPB / 2 + 8 * CPB + CPB;
`endif

   logic       basys_clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] board_type = ROLE_SLAVE;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       perr;
   logic       busy;

   board_link_rx dut (
      .basys_clk  (basys_clk),
      .reset      (reset),
      .board_type (board_type),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
`ifdef LINK_PARITY_EN
      .parity_err (perr),
`endif
      .busy       (busy)
   );

`ifndef LINK_PARITY_EN
   assign perr = 1'b0;
`endif

   always #5 basys_clk = ~basys_clk;

   int cyc = 0;
   always @(posedge basys_clk) cyc <= cyc + 1;

   // kind: 0 good byte, 1 framing error, 2 parity error
   typedef struct {
      int         kind;
      logic [7:0] data;
      int         when;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] last_good = 8'h00;
   bit         busy_seen = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop one expectation per strobe.
   always @(negedge basys_clk) begin : mon
      int   kind;
      exp_t e;
      if (busy) busy_seen = 1'b1;
      if (!reset && (rx_valid || frame_err || perr)) begin
         kind = rx_valid ? 0 : (frame_err ? 1 : 2);
         check("one_strobe", int'(rx_valid) + int'(frame_err) + int'(perr), 1);
         if (sb.size() == 0) begin
            check("unexpected_strobe", kind, -1);
         end else begin
            e = sb.pop_front();
            check("strobe_kind", kind, e.kind);
            check("rx_data", int'(rx_data), int'(e.data));
            n_tests++;
            if (cyc < e.when - 1 || cyc > e.when + 1) begin
               n_fail++;
               $display("FAIL latency: strobe at cycle %0d expected %0d +/-1", cyc, e.when);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge basys_clk);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      wait_cyc(n);
   endtask

   // Called at a negedge; returns at a negedge right after the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_ok, input bit expect_rx);
      exp_t e;
      if (expect_rx) begin
         e.when = cyc + FRAME_LAT;
         if (!stop_bit) begin
            e.kind = 1; e.data = last_good;
`ifdef LINK_PARITY_EN
         end else if (!par_ok) begin
            e.kind = 2; e.data = last_good;
`endif
         end else begin
            e.kind = 0; e.data = d;
            last_good = d;
         end
         sb.push_back(e);
      end
      rx_in = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         wait_cyc(CPB);
      end
`ifdef LINK_PARITY_EN
      rx_in = (^d) ^ ~par_ok;
      wait_cyc(CPB);
`else
      if (par_ok === 1'bx) rx_in = 1'b1;
`endif
      rx_in = stop_bit;
      wait_cyc(CPB);
      rx_in = 1'b1;
   endtask

   initial begin
      wait_cyc(4);
      check("reset_rx_data", int'(rx_data), 0);
      check("reset_rx_valid", int'(rx_valid), 0);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_busy", int'(busy), 0);
      reset = 1'b0;
      idle(20);

      // Single good byte with latency check.
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      idle(50);

      // Back-to-back stream: two random bytes then 3C, C3.
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1);
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
      idle(50);

      // Stop bit low: framing error, data held.
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      idle(1000);
      check("hold_after_ferr", int'(rx_data), int'(last_good));

      // 200-cycle glitch on the idle line.
      rx_in = 1'b0;
      wait_cyc(200);
      rx_in = 1'b1;
      wait_cyc(100);
      check("glitch_busy_mid", int'(busy), 1);
      wait_cyc(300);
      check("glitch_busy_end", int'(busy), 0);

      // Master role: receiver ignores the line.
      board_type = ROLE_MASTER;
      busy_seen  = 1'b0;
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      idle(50);
      check("master_busy_seen", int'(busy_seen), 0);

      // Role drops to unset mid-frame.
      board_type = ROLE_SLAVE;
      idle(20);
      rx_in = 1'b0;
      wait_cyc(CPB);
      rx_in = 1'b1;
      wait_cyc(3 * CPB);
      check("abort_busy_before", int'(busy), 1);
      board_type = ROLE_UNSET;
      wait_cyc(1);
      check("abort_busy_after", int'(busy), 0);
      idle(2 * CPB);
      board_type = ROLE_SLAVE;
      idle(20);

`ifdef LINK_PARITY_EN
      // Wrong parity bit on 8'h07.
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      idle(50);
      check("hold_after_perr", int'(rx_data), int'(last_good));
`endif

      // Reset in the middle of the data bits.
      rx_in = 1'b0;
      wait_cyc(3 * CPB);
      check("pre_reset_busy", int'(busy), 1);
      reset = 1'b1;
      wait_cyc(1);
      check("mid_reset_rx_data", int'(rx_data), 0);
      check("mid_reset_rx_valid", int'(rx_valid), 0);
      check("mid_reset_frame_err", int'(frame_err), 0);
      check("mid_reset_busy", int'(busy), 0);
      rx_in = 1'b1;
      last_good = 8'h00;
      wait_cyc(2);
      reset = 1'b0;
      idle(2 * CPB);

      for (int i = 0; i < 20000 && sb.size() != 0; i++) wait_cyc(1);
      check("pending_expectations", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/board_link_rx.md
# board_link_rx

Slave-side serial receiver for the inter-board link between two Basys 3 boards. When the board is configured as slave (board_type == 2), it samples the single-wire Pmod line driven by the master board's link transmitter. It decodes 8N1 frames (optionally 8E1) and presents each received byte with a one-cycle valid strobe and error flags to the slave's game logic. In any other board role the receiver is held idle and ignores the line.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, basys_clk frequency in Hz
- BAUD, 115_200, link bit rate
- CLKS_PER_BIT, CLK_FREQ/BAUD (868), clocks per bit; derived, not overridden

Ports:
- basys_clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- board_type  in  2  role code: 1 master, 2 slave, 3 standalone, 0 unset
- rx_in  in  1  asynchronous link line from master Pmod; idles high
- rx_data  out  8  last good byte, LSB first on wire; held until next good frame
- rx_valid  out  1  one-cycle strobe; rx_data updated this cycle
- frame_err  out  1  one-cycle strobe; stop bit sampled low
- parity_err  out  1  one-cycle strobe; exists only with LINK_PARITY_EN
- busy  out  1  high whenever state != IDLE

## Operation
- rx_in passes through a 2-FF synchronizer; all logic uses the synchronized value rx_s.
- enable = (board_type == 2). If enable is low, the FSM is forced to IDLE and counters are cleared on the same edge. Outputs hold, and strobes are 0.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: on rx_s == 0 with enable high, go to START and clear baud_cnt.
- START: at baud_cnt == CLKS_PER_BIT/2 - 1 (433), resample. If rx_s == 1, the event was a glitch: return to IDLE with no strobe. Otherwise clear baud_cnt, clear bit_idx, and go to DATA.
- DATA: at baud_cnt == CLKS_PER_BIT - 1, shift rx_s into shift_reg[7] (right shift, so LSB arrives first) and increment bit_idx. After bit_idx 7, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: sample one bit and compare it with the XOR of the 8 data bits (even parity). Latch the mismatch into par_bad, then go to STOP.
- STOP: sample at the full bit period.
  - rx_s == 1 and par_bad clear: rx_data <= shift_reg, rx_valid = 1.
  - rx_s == 0: frame_err = 1 and rx_data is unchanged.
  - rx_s == 1 and par_bad set: parity_err = 1 and rx_data is unchanged.
  - In all cases return to IDLE.
- baud_cnt is 10 bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each sample.
- A line held low after a bad stop bit starts a new frame immediately from IDLE. This is accepted; the next frame will likely flag frame_err.

## Timing
- Reset values: rx_data = 8'h00, rx_valid = 0, frame_err = 0, parity_err = 0, busy = 0. FSM is IDLE, counters are 0, synchronizer flops are 1, shift_reg = 0.
- Latency from the rx_in falling edge to the rx_valid pulse: 2 (sync) + 1 (IDLE detect) + 434 (half bit) + 8×868 + 868 (stop) cycles = 8249 cycles without parity. Add 868 with LINK_PARITY_EN. Tolerance is ±1 cycle for edge alignment.
- Strobes are registered and exactly one cycle wide. rx_data is valid in the same cycle as rx_valid and stays stable afterwards.
- A reset mid-frame takes priority over everything: the next edge is in reset state and no strobe fires.
- board_type leaving 2 mid-frame aborts the frame the same cycle it is seen, with no strobe.
- Back-to-back frames (a start bit immediately after the stop bit) must be received without loss. IDLE is re-entered at mid-stop, which leaves a half-bit margin.

## Configuration
- LINK_PARITY_EN is defined: the PARITY state and parity_err port exist, and the frame is 11 bits (8E1).
- LINK_PARITY_EN is not defined: there is no PARITY state and no parity_err port, and the frame is 10 bits (8N1).
- The master-side transmitter must be built with the same setting.

## Structure
- Shared package link_pkg holds the FSM state encodings, LINK_BAUD_DEFAULT = 115_200, and the role codes ROLE_MASTER = 1, ROLE_SLAVE = 2, ROLE_SOLO = 3. The transmitter and the role select logic use these same constants.
- One sub-module, link_sync2: a generic 2-FF synchronizer with reset value 1.

## Test plan
- Slave role, send 8'hA5 as 8N1 at 868 clks/bit → a single rx_valid with rx_data = 8'hA5 at 8249±1 cycles after the falling edge; no error strobe.
- Send 8'h3C immediately followed by 8'hC3 back-to-back → two rx_valid pulses, data 3C then C3.
- Send 8'h5A with the stop bit driven 0 → frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value.
- Drive a 200-cycle low glitch on the idle line → return to IDLE after the half-bit check, busy drops, no strobes.
- Set board_type = 1 and send 8'hFF → busy stays 0, no strobes. Switch board_type to 0 mid-frame while in slave role → frame aborted.
- With LINK_PARITY_EN, send 8'h07 with the parity bit = 0 (wrong; even parity requires 1) → parity_err pulses, rx_data unchanged. Assert reset mid-DATA → all outputs return to reset values on the next edge.
